// File: rtl/instr_mem_arbiter_if.sv
// Shared instruction-SRAM port bundle: fetch port (p0), bus port (p1) and the SRAM side.
// The arbiter takes the slave view; the surrounding requesters/SRAM take the master view.
interface instr_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  p0_req_i;
  logic                  p0_gnt_o;
  logic [ADDR_WIDTH-1:0] p0_addr_i;
  logic                  p0_rvalid_o;
  logic [DATA_WIDTH-1:0] p0_rdata_o;

  logic                  p1_req_i;
  logic                  p1_gnt_o;
  logic [ADDR_WIDTH-1:0] p1_addr_i;
  logic                  p1_we_i;
  logic [BE_W-1:0]       p1_be_i;
  logic [DATA_WIDTH-1:0] p1_wdata_i;
  logic                  p1_rvalid_o;
  logic [DATA_WIDTH-1:0] p1_rdata_o;

  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic [BE_W-1:0]       mem_be_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  p0_req_i, p0_addr_i,
    input  p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
    input  mem_rdata_i,
    output p0_gnt_o, p0_rvalid_o, p0_rdata_o,
    output p1_gnt_o, p1_rvalid_o, p1_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

  modport master (
    output p0_req_i, p0_addr_i,
    output p1_req_i, p1_addr_i, p1_we_i, p1_be_i, p1_wdata_i,
    output mem_rdata_i,
    input  p0_gnt_o, p0_rvalid_o, p0_rdata_o,
    input  p1_gnt_o, p1_rvalid_o, p1_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/instr_mem_arbiter.sv
// Fixed-priority two-port arbiter in front of the 1-cycle-latency instruction SRAM.
// Fetch (p0) wins contention; a saturating loss counter force-grants the bus port (p1).
module instr_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_mem_arbiter_if.slave bus
);
  localparam int         BE_W   = DATA_WIDTH / 8;
  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_owner_q, rsp_owner_d;
  logic                  p0_gnt, p1_gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [BE_W-1:0]       be;
  logic [DATA_WIDTH-1:0] wdata;

  always_comb begin
    p0_gnt = bus.p0_req_i & ~(bus.p1_req_i & (wait_cnt_q == MAX_W8));
    p1_gnt = bus.p1_req_i & ~p0_gnt;

    addr  = '0;
    we    = 1'b0;
    be    = '0;
    wdata = '0;
    if (p0_gnt) begin
      addr = bus.p0_addr_i;
      be   = '1;
    end else if (p1_gnt) begin
      addr  = bus.p1_addr_i;
      we    = bus.p1_we_i;
      be    = bus.p1_be_i;
      wdata = bus.p1_wdata_i;
    end

    // Only consecutive lost cycles count; any gap or win restarts the count.
    wait_cnt_d = wait_cnt_q;
    if (!bus.p1_req_i || p1_gnt)
      wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_W8)
      wait_cnt_d = wait_cnt_q + 8'd1;

    rsp_valid_d = p0_gnt | p1_gnt;
    rsp_owner_d = p1_gnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign bus.p0_gnt_o    = p0_gnt;
  assign bus.p1_gnt_o    = p1_gnt;
  assign bus.mem_req_o   = p0_gnt | p1_gnt;
  assign bus.mem_addr_o  = addr;
  assign bus.mem_we_o    = we;
  assign bus.mem_be_o    = be;
  assign bus.mem_wdata_o = wdata;

  assign bus.p0_rvalid_o = rsp_valid_q & ~rsp_owner_q;
  assign bus.p1_rvalid_o = rsp_valid_q &  rsp_owner_q;
  assign bus.p0_rdata_o  = bus.mem_rdata_i;
  assign bus.p1_rdata_o  = bus.mem_rdata_i;
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Vector-table bench for instr_mem_arbiter with a behavioural SRAM and a response scoreboard.
module tb_instr_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_mem_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) ifc ();

  instr_mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Behavioural SRAM driven purely by the DUT's memory port.
  logic [31:0] sram [logic [15:0]];
  always @(posedge clk) begin
    if (ifc.mem_req_o) begin
      logic [31:0] w;
      w = sram.exists(ifc.mem_addr_o) ? sram[ifc.mem_addr_o] : 32'h0;
      if (ifc.mem_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ifc.mem_be_o[b]) w[8*b +: 8] = ifc.mem_wdata_o[8*b +: 8];
        sram[ifc.mem_addr_o] = w;
      end else begin
        ifc.mem_rdata_i <= w;
      end
    end
  end

  // Reference memory image, updated from the expected (not observed) grants.
  logic [31:0] ref_mem [logic [15:0]];

  typedef struct {
    logic        rst_n;
    logic        p0_req;
    logic [15:0] p0_addr;
    logic        p1_req;
    logic        p1_we;
    logic [15:0] p1_addr;
    logic [3:0]  p1_be;
    logic [31:0] p1_wdata;
    logic        e0;
    logic        e1;
  } vec_t;

  typedef struct {
    logic        p1;
    logic        chk_data;
    logic [31:0] data;
    int          due;
  } rsp_t;

  vec_t vecs[$];
  rsp_t sb[$];

  function automatic vec_t mk(logic r, logic p0r, logic [15:0] p0a, logic p1r, logic we,
                              logic [15:0] p1a, logic [3:0] be, logic [31:0] wd,
                              logic e0, logic e1);
    vec_t v;
    v.rst_n = r;   v.p0_req = p0r; v.p0_addr = p0a; v.p1_req = p1r; v.p1_we = we;
    v.p1_addr = p1a; v.p1_be = be; v.p1_wdata = wd; v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  task automatic cmp(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    rsp_t        e;
    logic        ev0, ev1;
    logic [15:0] ea;
    logic        ewe;
    logic [3:0]  ebe;
    logic [31:0] ewd, w;
    @(posedge clk); #1;
    rst_n          = v.rst_n;
    ifc.p0_req_i   = v.p0_req;
    ifc.p0_addr_i  = v.p0_addr;
    ifc.p1_req_i   = v.p1_req;
    ifc.p1_we_i    = v.p1_we;
    ifc.p1_addr_i  = v.p1_addr;
    ifc.p1_be_i    = v.p1_be;
    ifc.p1_wdata_i = v.p1_wdata;
    @(negedge clk);

    ev0 = 1'b0; ev1 = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      ev0 = ~e.p1; ev1 = e.p1;
      if (e.chk_data) begin
        if (e.p1) cmp("p1_rdata", 64'(ifc.p1_rdata_o), 64'(e.data));
        else      cmp("p0_rdata", 64'(ifc.p0_rdata_o), 64'(e.data));
      end
    end
    cmp("rvalid", 64'({ifc.p0_rvalid_o, ifc.p1_rvalid_o}), 64'({ev0, ev1}));
    cmp("gnt", 64'({ifc.p0_gnt_o, ifc.p1_gnt_o}), 64'({v.e0, v.e1}));
    cmp("mem_req", 64'(ifc.mem_req_o), 64'(v.e0 | v.e1));

    ea = '0; ewe = 1'b0; ebe = '0; ewd = '0;
    if (v.e0) begin
      ea = v.p0_addr; ebe = 4'hF;
    end else if (v.e1) begin
      ea = v.p1_addr; ewe = v.p1_we; ebe = v.p1_be; ewd = v.p1_wdata;
    end
    cmp("mem_bus", 64'({ifc.mem_addr_o, ifc.mem_we_o, ifc.mem_be_o, ifc.mem_wdata_o}),
        64'({ea, ewe, ebe, ewd}));

    if (v.e0 || v.e1) begin
      w = ref_mem.exists(ea) ? ref_mem[ea] : 32'h0;
      if (ewe) begin
        for (int b = 0; b < 4; b++)
          if (ebe[b]) w[8*b +: 8] = ewd[8*b +: 8];
        ref_mem[ea] = w;
      end
      // A grant issued while reset is asserted never produces a response.
      if (v.rst_n) begin
        e.p1 = v.e1; e.chk_data = ~ewe; e.data = w; e.due = cyc + 1;
        sb.push_back(e);
      end
    end
  endtask

  initial begin
    ifc.p0_req_i = 0; ifc.p0_addr_i = 0; ifc.p1_req_i = 0; ifc.p1_we_i = 0;
    ifc.p1_addr_i = 0; ifc.p1_be_i = 0; ifc.p1_wdata_i = 0; ifc.mem_rdata_i = 0;
    sram[16'h0010] = 32'hDEADBEEF; ref_mem[16'h0010] = 32'hDEADBEEF;
    sram[16'h0014] = 32'h00000013; ref_mem[16'h0014] = 32'h00000013;
    sram[16'h0020] = 32'hAABBCCDD; ref_mem[16'h0020] = 32'hAABBCCDD;

    // reset
    repeat (2) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // P0-only fetches back to back
    vecs.push_back(mk(1, 1, 16'h0010, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0014, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // P1-only partial write then read-back
    vecs.push_back(mk(1, 0, 0, 1, 1, 16'h0020, 4'b0011, 32'h12345678, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0020, 4'hF, 32'h0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Continuous contention: four P0 wins, forced P1, P0 again
    repeat (4) vecs.push_back(mk(1, 1, 16'h0010, 1, 0, 16'h0014, 4'hF, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0010, 1, 0, 16'h0014, 4'hF, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h0010, 1, 0, 16'h0014, 4'hF, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // P1 drops after 3 losses: count restarts, needs 4 more losses
    repeat (3) vecs.push_back(mk(1, 1, 16'h0014, 1, 0, 16'h0020, 4'hF, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0014, 0, 0, 16'h0020, 4'hF, 0, 1, 0));
    repeat (4) vecs.push_back(mk(1, 1, 16'h0014, 1, 0, 16'h0020, 4'hF, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h0014, 1, 0, 16'h0020, 4'hF, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Alternating P0, P1, P0 with no bubble
    vecs.push_back(mk(1, 1, 16'h0010, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 16'h0020, 4'hF, 0, 0, 1));
    vecs.push_back(mk(1, 1, 16'h0014, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset mid-contention clears the loss count and drops the in-flight response.
    repeat (3) apply(mk(1, 1, 16'h0010, 1, 0, 16'h0020, 4'hF, 0, 1, 0));
    apply(mk(0, 1, 16'h0010, 1, 0, 16'h0020, 4'hF, 0, 1, 0));
    repeat (4) apply(mk(1, 1, 16'h0010, 1, 0, 16'h0020, 4'hF, 0, 1, 0));
    apply(mk(1, 1, 16'h0010, 1, 0, 16'h0020, 4'hF, 0, 0, 1));
    apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // P1 read granted in the reset cycle: SRAM is driven, response never returns.
    apply(mk(0, 0, 0, 1, 0, 16'h0014, 4'hF, 0, 0, 1));
    repeat (2) apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    cmp("sb_drain", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
